// File: rtl/epp_bram_bridge.sv
// EPP slave bridging Digilent parallel-port address/data cycles onto the 8-bit BRAM bus.
// Also issues the dataStb command pulse to the controller and reports its busy/error status.
module epp_bram_bridge #(
  parameter int ADDR_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              eppAstb,
  input  logic              eppDstb,
  input  logic              eppWr,
  input  logic [7:0]        eppDataIn,
  output logic [7:0]        eppDataOut,
  output logic              eppDataOe,
  output logic              eppWait,
  output logic [ADDR_W-1:0] busBramAddr,
  output logic [7:0]        busBramOut,
  input  logic [7:0]        busBramIn,
  output logic              bramWe,
  output logic              dataStb,
  input  logic              stmBusy,
  output logic [2:0]        dbgState
);

  localparam int HI_W = ADDR_W - 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AWR  = 3'd1,
    ARD  = 3'd2,
    DWR  = 3'd3,
    DRD1 = 3'd4,
    DRD2 = 3'd5,
    ACK  = 3'd6
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] astbSync;
  logic [SYNC_STAGES-1:0] dstbSync;
  logic [SYNC_STAGES-1:0] wrSync;
  logic                   astbS;
  logic                   dstbS;
  logic                   wrS;
  logic [7:0]             eppReg;
  logic                   errFlag;
  logic                   addrCycle;
  logic                   incPending;
  logic                   blockData;
  logic [7:0]             regRdData;

  assign astbS    = astbSync[SYNC_STAGES-1];
  assign dstbS    = dstbSync[SYNC_STAGES-1];
  assign wrS      = wrSync[SYNC_STAGES-1];
  assign dbgState = state;

  // Strobes idle high, so the synchronizers reset to 1 and never fake a cycle out of reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      astbSync <= '1;
      dstbSync <= '1;
      wrSync   <= '0;
    end else begin
      astbSync <= {astbSync[SYNC_STAGES-2:0], eppAstb};
      dstbSync <= {dstbSync[SYNC_STAGES-2:0], eppDstb};
      wrSync   <= {wrSync[SYNC_STAGES-2:0], eppWr};
    end
  end

  always_comb begin
    regRdData = 8'h00;
    case (eppReg)
      8'h00:   regRdData = busBramAddr[7:0];
      8'h01:   regRdData = 8'(busBramAddr[ADDR_W-1:8]);
      8'h03:   regRdData = {6'b0, errFlag, stmBusy};
      default: regRdData = 8'h00;
    endcase
  end

  // Handshake: eppWait rises once the access has taken effect (write done or read data on
  // eppDataOut) and stays high until the host releases the strobe that opened the cycle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= IDLE;
      eppDataOut  <= 8'h00;
      eppDataOe   <= 1'b0;
      eppWait     <= 1'b0;
      busBramAddr <= '0;
      busBramOut  <= 8'h00;
      bramWe      <= 1'b0;
      dataStb     <= 1'b0;
      eppReg      <= 8'h00;
      errFlag     <= 1'b0;
      addrCycle   <= 1'b0;
      incPending  <= 1'b0;
      blockData   <= 1'b0;
    end else begin
      bramWe  <= 1'b0;
      dataStb <= 1'b0;

      // A data strobe that arrived together with an address strobe is held off until both release.
      if (astbS && dstbS)
        blockData <= 1'b0;
      else if (state == IDLE && !astbS && !dstbS)
        blockData <= 1'b1;

      case (state)
        IDLE: begin
          if (!astbS) begin
            addrCycle <= 1'b1;
            if (wrS) begin
              state     <= ARD;
              eppDataOe <= 1'b1;
            end else begin
              state <= AWR;
            end
          end else if (!dstbS && !blockData) begin
            addrCycle <= 1'b0;
            if (wrS) begin
              state     <= DRD1;
              eppDataOe <= 1'b1;
            end else begin
              state <= DWR;
            end
          end
        end
        AWR: begin
          eppReg     <= eppDataIn;
          eppWait    <= 1'b1;
          incPending <= 1'b0;
          state      <= ACK;
        end
        ARD: begin
          eppDataOut <= eppReg;
          eppWait    <= 1'b1;
          incPending <= 1'b0;
          state      <= ACK;
        end
        DWR: begin
          case (eppReg)
            8'h00: busBramAddr <= {busBramAddr[ADDR_W-1:8], eppDataIn};
            8'h01: busBramAddr <= {eppDataIn[HI_W-1:0], busBramAddr[7:0]};
            8'h02: begin
              busBramOut <= eppDataIn;
              bramWe     <= 1'b1;
            end
            8'h03: begin
              dataStb <= eppDataIn[0] & ~stmBusy;
              errFlag <= (errFlag & ~eppDataIn[1]) | (eppDataIn[0] & stmBusy);
            end
            default: ;
          endcase
          incPending <= (eppReg == 8'h02);
          eppWait    <= 1'b1;
          state      <= ACK;
        end
        DRD1: begin
          // BRAM data needs one more cycle; other registers answer immediately.
          if (eppReg == 8'h02) begin
            state <= DRD2;
          end else begin
            eppDataOut <= regRdData;
            eppWait    <= 1'b1;
            incPending <= 1'b0;
            state      <= ACK;
          end
        end
        DRD2: begin
          eppDataOut <= busBramIn;
          eppWait    <= 1'b1;
          incPending <= 1'b1;
          state      <= ACK;
        end
        ACK: begin
          if (addrCycle ? astbS : dstbS) begin
            eppWait   <= 1'b0;
            eppDataOe <= 1'b0;
            state     <= IDLE;
            if (incPending)
              busBramAddr <= busBramAddr + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_epp_bram_bridge.sv
// Directed bench for epp_bram_bridge: host EPP tasks, a BRAM model, and a write scoreboard.
module tb_epp_bram_bridge;

  logic        clk = 1'b0;
  logic        rstN;
  logic        eppAstb, eppDstb, eppWr;
  logic [7:0]  eppDataIn;
  logic [7:0]  eppDataOut;
  logic        eppDataOe, eppWait;
  logic [11:0] busBramAddr;
  logic [7:0]  busBramOut;
  logic [7:0]  busBramIn;
  logic        bramWe, dataStb, stmBusy;
  logic [2:0]  dbgState;

  int vectors = 0;
  int miscompares = 0;
  int stbCount = 0;
  int unexpectedWe = 0;
  logic [19:0] exp_q[$];
  logic [7:0]  mem [4096];

  epp_bram_bridge #(.ADDR_W(12), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstN(rstN),
    .eppAstb(eppAstb), .eppDstb(eppDstb), .eppWr(eppWr),
    .eppDataIn(eppDataIn), .eppDataOut(eppDataOut), .eppDataOe(eppDataOe),
    .eppWait(eppWait), .busBramAddr(busBramAddr), .busBramOut(busBramOut),
    .busBramIn(busBramIn), .bramWe(bramWe), .dataStb(dataStb),
    .stmBusy(stmBusy), .dbgState(dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // BRAM model with one-cycle read latency
  initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (bramWe) mem[busBramAddr] <= busBramOut;
    busBramIn <= mem[busBramAddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every BRAM write must match the next expected {addr, data}
  always @(negedge clk) begin
    if (rstN === 1'b1) begin
      if (bramWe === 1'b1) begin
        if (exp_q.size() == 0) unexpectedWe++;
        else chk("bram_write", {12'h0, busBramAddr, busBramOut}, {12'h0, exp_q.pop_front()});
      end
      if (dataStb === 1'b1) stbCount++;
    end
  end

  task automatic chkResetOuts(input string tag);
    chk({tag, "_dataOut"}, eppDataOut, 0);
    chk({tag, "_dataOe"}, eppDataOe, 0);
    chk({tag, "_wait"}, eppWait, 0);
    chk({tag, "_addr"}, busBramAddr, 0);
    chk({tag, "_bramOut"}, busBramOut, 0);
    chk({tag, "_we"}, bramWe, 0);
    chk({tag, "_stb"}, dataStb, 0);
  endtask

  task automatic waitWait(input logic val, output int n);
    bit seen = 0;
    n = 0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      seen = (eppWait === val);
    end
  endtask

  // driver: one full EPP cycle; lat = negedges from strobe fall to eppWait high
  task automatic eppCycle(input bit isAddr, input bit isRead, input logic [7:0] wdata,
                          output logic [7:0] rdata, output int lat);
    int rel;
    @(negedge clk);
    eppWr = isRead;
    eppDataIn = wdata;
    if (isAddr) eppAstb = 1'b0; else eppDstb = 1'b0;
    waitWait(1'b1, lat);
    chk("wait_rise_timeout", (eppWait === 1'b1), 1);
    rdata = eppDataOut;
    chk("oe_during_ack", eppDataOe, isRead);
    eppAstb = 1'b1;
    eppDstb = 1'b1;
    waitWait(1'b0, rel);
    chk("wait_fall_latency", rel, 3);
    chk("oe_after_cycle", eppDataOe, 0);
  endtask

  task automatic addrWr(input logic [7:0] d);
    logic [7:0] r; int l;
    eppCycle(1'b1, 1'b0, d, r, l);
  endtask
  task automatic dataWr(input logic [7:0] d);
    logic [7:0] r; int l;
    eppCycle(1'b0, 1'b0, d, r, l);
  endtask
  task automatic addrRd(output logic [7:0] d);
    int l;
    eppCycle(1'b1, 1'b1, 8'h00, d, l);
  endtask
  task automatic dataRd(output logic [7:0] d, output int l);
    eppCycle(1'b0, 1'b1, 8'h00, d, l);
  endtask

  initial begin
    logic [7:0] rd;
    int lat;
    int n;
    bit sawWait;
    rstN = 1'b0; eppAstb = 1'b1; eppDstb = 1'b1; eppWr = 1'b0;
    eppDataIn = 8'h00; stmBusy = 1'b0;
    repeat (4) @(negedge clk);
    chkResetOuts("reset");
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // address setup and three BRAM writes with auto-increment
    addrWr(8'h00); dataWr(8'h34);
    addrWr(8'h01); dataWr(8'h02);
    chk("addr_set_234", busBramAddr, 12'h234);
    addrWr(8'h02);
    exp_q.push_back({12'h234, 8'hAA}); dataWr(8'hAA);
    exp_q.push_back({12'h235, 8'hBB}); dataWr(8'hBB);
    exp_q.push_back({12'h236, 8'hCC}); dataWr(8'hCC);
    chk("addr_after_writes", busBramAddr, 12'h237);

    // read back through the data port
    addrWr(8'h00); dataWr(8'h34);
    addrWr(8'h01); dataWr(8'h02);
    addrWr(8'h02);
    addrRd(rd); chk("eppreg_readback", rd, 8'h02);
    dataRd(rd, lat); chk("bram_rd0", rd, 8'hAA); chk("bram_rd_latency", lat, 5);
    dataRd(rd, lat); chk("bram_rd1", rd, 8'hBB);
    chk("addr_after_reads", busBramAddr, 12'h236);

    // reg1 upper bits read as zero, then wrap at 0xFFF
    addrWr(8'h01); dataWr(8'hF5);
    dataRd(rd, lat); chk("reg1_upper_zero", rd, 8'h05); chk("reg_rd_latency", lat, 4);
    dataWr(8'h0F);
    addrWr(8'h00); dataWr(8'hFF);
    chk("addr_set_fff", busBramAddr, 12'hFFF);
    addrWr(8'h02);
    exp_q.push_back({12'hFFF, 8'h11}); dataWr(8'h11);
    chk("addr_wrap", busBramAddr, 12'h000);
    addrWr(8'h00); dataRd(rd, lat); chk("reg0_after_wrap", rd, 8'h00);
    addrWr(8'h01); dataRd(rd, lat); chk("reg1_after_wrap", rd, 8'h00);

    // command pulse, busy rejection and error flag
    addrWr(8'h03);
    dataWr(8'h01); chk("stb_one_pulse", stbCount, 1);
    dataRd(rd, lat); chk("status_idle", rd, 8'h00);
    stmBusy = 1'b1;
    dataWr(8'h01); chk("stb_rejected", stbCount, 1);
    dataRd(rd, lat); chk("status_err_busy", rd, 8'h03);
    dataWr(8'h02);
    dataRd(rd, lat); chk("status_cleared", rd, 8'h01);
    dataWr(8'h03); chk("stb_both_bits", stbCount, 1);
    dataRd(rd, lat); chk("status_clear_then_set", rd, 8'h03);
    stmBusy = 1'b0;
    dataWr(8'h02);
    dataRd(rd, lat); chk("status_final", rd, 8'h00);

    // unmapped register: acknowledged, reads zero
    addrWr(8'h55); dataWr(8'h77);
    dataRd(rd, lat); chk("unmapped_read", rd, 8'h00);

    // simultaneous strobes: address wins, data held off until both release
    @(negedge clk);
    eppWr = 1'b0; eppDataIn = 8'h02; eppAstb = 1'b0; eppDstb = 1'b0;
    waitWait(1'b1, n); chk("both_addr_ack", n, 4);
    eppAstb = 1'b1;
    waitWait(1'b0, n); chk("both_addr_release", n, 3);
    sawWait = 0;
    repeat (10) begin
      @(negedge clk);
      if (eppWait !== 1'b0) sawWait = 1;
    end
    chk("blocked_dstb_no_ack", sawWait, 0);
    eppDstb = 1'b1;
    repeat (3) @(negedge clk);
    addrRd(rd); chk("both_eppreg", rd, 8'h02);
    exp_q.push_back({12'h000, 8'h5C}); dataWr(8'h5C);
    chk("addr_after_unblock", busBramAddr, 12'h001);

    // reset during ACK of a data write
    stmBusy = 1'b1;
    addrWr(8'h03); dataWr(8'h01);
    dataRd(rd, lat); chk("err_before_reset", rd, 8'h03);
    stmBusy = 1'b0;
    addrWr(8'h00);
    @(negedge clk);
    eppWr = 1'b0; eppDataIn = 8'h99; eppDstb = 1'b0;
    waitWait(1'b1, n); chk("rst_pre_ack", n, 4);
    chk("rst_pre_addr", busBramAddr, 12'h099);
    #2 rstN = 1'b0;
    #1 chkResetOuts("async_reset");
    repeat (3) @(negedge clk);
    eppDstb = 1'b1;
    @(negedge clk);
    rstN = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_idle_wait", eppWait, 0);
    addrRd(rd); chk("post_reset_eppreg", rd, 8'h00);
    dataRd(rd, lat); chk("post_reset_reg0", rd, 8'h00);
    addrWr(8'h03);
    dataRd(rd, lat); chk("post_reset_errflag", rd, 8'h00);

    // strobe held low across reset release is a fresh cycle
    @(negedge clk);
    rstN = 1'b0; eppWr = 1'b0; eppDataIn = 8'h66; eppDstb = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    waitWait(1'b1, n); chk("held_strobe_ack", n, 4);
    chk("held_strobe_addr", busBramAddr, 12'h066);
    eppDstb = 1'b1;
    waitWait(1'b0, n); chk("held_strobe_release", n, 3);
    dataRd(rd, lat); chk("held_strobe_reg0", rd, 8'h66);

    repeat (3) @(negedge clk);
    chk("unexpected_bram_we", unexpectedWe, 0);
    chk("bram_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
